seg_display_ctrl: RTL

Sequential successor to the calculator's combinational binary-to-7-segment decoder: a self-scanning, parametrised multi-digit display controller. It latches a result word and display mode, converts the word to BCD with an iterative double-dabble engine, and holds the digit pattern in a display buffer. It then time-multiplexes that buffer onto a common-anode 7-segment bank. It sits between the calculator ALU/result register and the board's segment and anode pins.

---
 rtl/seg_display_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
//
// Multi-digit common-anode 7-segment controller. It latches a value and a
// display mode, converts the value to BCD with an iterative double-dabble
// engine (one bit per cycle), writes the resulting digit patterns into a
// display buffer and continuously scans that buffer onto the digit bank.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   data      value to display, sampled on an accepted load
//   mode      00 unsigned dec, 01 signed dec, 10 error, 11 hex
//   blank_lz  leading-zero blanking enable, sampled with data
//   load      one-cycle conversion request
//   busy      conversion in progress
//   done      one-cycle pulse when the display buffer is rewritten
//   ovf       value did not fit; sticky until the next accepted load
//   anodes    one-hot active-high digit select, bit 0 = rightmost digit
//   segments  active-low {dp,g,f,e,d,c,b,a}, dp always 1
//
// Handshake: load acts as "valid" and ~busy as "ready". A request is
// accepted on any rising edge where load & ~busy; a load seen while busy is
// high is dropped. Each accepted request yields exactly one done pulse
// DATA_W+1 cycles later unless rst intervenes.

module seg_display_ctrl #(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic              blank_lz,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [DIGITS-1:0] anodes,
    output logic [7:0]        segments
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int BW   = 4 * DIGITS;                 // BCD register width
    localparam int NIB  = (DATA_W + 3) / 4;           // hex nibbles in data
    localparam int PADW = 4 * ((NIB > DIGITS) ? NIB : DIGITS);
    localparam int CW   = (DATA_W > 32) ? DATA_W : 32; // compare width
    localparam int CNTW = $clog2(DATA_W + 1);
    localparam int IW   = $clog2(DIGITS);
    localparam int SCW  = $clog2(SCAN_DIV);

    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] MODE_UDEC = 2'b00;
    localparam logic [1:0] MODE_SDEC = 2'b01;
    localparam logic [1:0] MODE_ERR  = 2'b10;
    localparam logic [1:0] MODE_HEX  = 2'b11;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Decimal range limits: a negative value needs one digit for the minus.
    localparam logic [CW-1:0] LIM_POS = CW'(pow10(DIGITS));
    localparam logic [CW-1:0] LIM_NEG = CW'(pow10(DIGITS - 1));

    function automatic logic [7:0] seg_code(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNTW-1:0]   cnt_q;
    logic              accept, shift_en, finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    accept  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == CNTW'(DATA_W - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Input capture and double-dabble datapath
    // ------------------------------------------------------------------
    logic              neg_in;
    logic [DATA_W-1:0] mag_in;

    // Two's-complement negation read back as unsigned, so the most
    // negative input yields 2^(DATA_W-1) rather than wrapping.
    assign neg_in = (mode == MODE_SDEC) & data[DATA_W-1];
    assign mag_in = neg_in ? (~data + DATA_W'(1)) : data;

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mag_q;
    logic [DATA_W-1:0] sh_q;
    logic [1:0]        mode_q;
    logic              blz_q;
    logic              neg_q;
    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_shift;

    // Add-3 correction on every digit >= 5, then shift in the next
    // magnitude bit. Carries out of the top digit only occur for values
    // that overflow, which are caught separately by the range compare.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[BW-2:0], sh_q[DATA_W-1]};
    end

    // ------------------------------------------------------------------
    // Buffer image assembled at the end of a conversion
    // ------------------------------------------------------------------
    logic [PADW-1:0] data_pad;
    logic            hex_drop;
    logic            dec_ovf;
    logic [3:0]      dig [DIGITS];
    logic [IW-1:0]   msd;
    logic [7:0]      buf_new [DIGITS];
    logic            new_ovf;

    assign data_pad = PADW'(data_q);

    generate
        if (NIB > DIGITS) begin : g_hex_drop
            assign hex_drop = |data_pad[PADW-1:4*DIGITS];
        end else begin : g_hex_fit
            assign hex_drop = 1'b0;
        end
    endgenerate

    assign dec_ovf = (CW'(mag_q) >= (neg_q ? LIM_NEG : LIM_POS));

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            dig[i] = (mode_q == MODE_HEX) ? data_pad[4*i +: 4] : bcd_q[4*i +: 4];
        end
    end

    // Position of the most significant nonzero digit; 0 when all zero so
    // digit 0 always survives blanking.
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig[i] != 4'd0) begin
                msd = IW'(i);
            end
        end
    end

    always_comb begin
        new_ovf = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            buf_new[i] = SEG_BLANK;
        end
        case (mode_q)
            MODE_ERR: begin
                buf_new[DIGITS-1] = SEG_E;
            end
            MODE_HEX: begin
                new_ovf = hex_drop;
                for (int i = 0; i < DIGITS; i++) begin
                    buf_new[i] = (blz_q && (i > int'(msd))) ? SEG_BLANK : seg_code(dig[i]);
                end
            end
            default: begin
                if (dec_ovf) begin
                    new_ovf           = 1'b1;
                    buf_new[DIGITS-1] = SEG_E;
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        buf_new[i] = (blz_q && (i > int'(msd))) ? SEG_BLANK : seg_code(dig[i]);
                    end
                    // A fitting negative value always leaves room above msd.
                    if (neg_q) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (blz_q ? (i == int'(msd) + 1) : (i == DIGITS - 1)) begin
                                buf_new[i] = SEG_MINUS;
                            end
                        end
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers and display buffer
    // ------------------------------------------------------------------
    logic [7:0] buf_q [DIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            data_q <= '0;
            mag_q  <= '0;
            sh_q   <= '0;
            mode_q <= MODE_UDEC;
            blz_q  <= 1'b0;
            neg_q  <= 1'b0;
            bcd_q  <= '0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                buf_q[i] <= SEG_BLANK;
            end
        end else begin
            done <= finish;
            if (accept) begin
                data_q <= data;
                mode_q <= mode;
                blz_q  <= blank_lz;
                neg_q  <= neg_in;
                mag_q  <= mag_in;
                sh_q   <= mag_in;
                bcd_q  <= '0;
                cnt_q  <= '0;
                ovf    <= 1'b0;
            end
            if (shift_en) begin
                bcd_q <= bcd_shift;
                sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
                cnt_q <= cnt_q + CNTW'(1);
            end
            if (finish) begin
                buf_q <= buf_new;
                ovf   <= new_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit scanning, free-running and independent of conversions
    // ------------------------------------------------------------------
    logic [SCW-1:0] scan_cnt, scan_d;
    logic [IW-1:0]  idx, idx_d;
    logic           scan_wrap;

    always_comb begin
        scan_wrap = (scan_cnt == SCW'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_cnt + SCW'(1);
        idx_d     = idx;
        if (scan_wrap) begin
            idx_d = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end
    end

    // segments is looked up with the next index so it changes on the same
    // edge as anodes; a fresh buffer write appears one cycle after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            segments <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_d;
            idx      <= idx_d;
            segments <= buf_q[idx_d];
        end
    end

    assign anodes = DIGITS'(1) << idx;

endmodule
